// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard controller: forwarding selects and FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hazard_pkg;

    // Operand source selects presented to exec
    localparam logic [1:0] FWD_REG = 2'd0;  // register file
    localparam logic [1:0] FWD_EX  = 2'd1;  // exec-stage result
    localparam logic [1:0] FWD_WB  = 2'd2;  // writeback value

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    // Exec is the younger producer, so it wins over writeback.
    function automatic logic [1:0] fwd_pick(input logic hit_ex, input logic hit_wb);
        if (hit_ex) begin
            return FWD_EX;
        end else if (hit_wb) begin
            return FWD_WB;
        end else begin
            return FWD_REG;
        end
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear (clear beats increment).
// Latency: count visible one clock after the increment.
// Backpressure: none; holds at all-ones instead of wrapping.
// Ports: clk_i/rst_i clock and async active-high reset, inc_i count enable,
//        clr_i synchronous clear, cnt_o current count.
module sat_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 inc_i,
    input  logic                 clr_i,
    output logic [CNT_WIDTH-1:0] cnt_o
);

    logic [CNT_WIDTH-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && !(&cnt_q)) begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Decode/exec hazard controller: RAW detection, operand forwarding, stall, flush refill window.
// Latency: issue/stall/forward selects are combinational; slots, state and counters registered.
// Backpressure: out_stall holds fetch/decode on an unforwardable RAW hazard; flush squashes issue.
// Ports: clock/reset; decode instruction (in_issue_valid, src/dst fields); in_flush from exec;
//        in_cnt_clear; out_issue/out_stall/out_fwd_sel_src*; out_state; stall/flush statistics.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_IDX_WIDTH = 4,
    parameter int FWD_ENABLE    = 1,
    parameter int FLUSH_BUBBLES = 2,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_issue_valid,
    input  logic                     in_src1_used,
    input  logic [REG_IDX_WIDTH-1:0] in_src1_idx,
    input  logic                     in_src2_used,
    input  logic [REG_IDX_WIDTH-1:0] in_src2_idx,
    input  logic                     in_dst_write,
    input  logic [REG_IDX_WIDTH-1:0] in_dst_idx,
    input  logic                     in_flush,
    input  logic                     in_cnt_clear,
    output logic                     out_issue,
    output logic                     out_stall,
    output logic [1:0]               out_fwd_sel_src1,
    output logic [1:0]               out_fwd_sel_src2,
    output logic                     out_state,
    output logic [CNT_WIDTH-1:0]     out_stall_cnt,
    output logic [CNT_WIDTH-1:0]     out_flush_cnt
);

    // Refill counter only needs to hold FLUSH_BUBBLES-1.
    localparam int BW = (FLUSH_BUBBLES > 1) ? $clog2(FLUSH_BUBBLES) : 1;
    localparam logic [BW-1:0] RELOAD = BW'(FLUSH_BUBBLES - 1);

    state_e                   state_q;
    logic [BW-1:0]            bub_q;
    logic                     ex_vld_q, wb_vld_q;
    logic [REG_IDX_WIDTH-1:0] ex_idx_q, wb_idx_q;
    logic                     ex_vld_d;
    logic [REG_IDX_WIDTH-1:0] ex_idx_d;

    logic hit_ex1, hit_ex2, hit_wb1, hit_wb2, raw, hz;
    logic run, accepted, stall_raw, flush_acc;

    assign hit_ex1 = in_src1_used & ex_vld_q & (in_src1_idx == ex_idx_q);
    assign hit_ex2 = in_src2_used & ex_vld_q & (in_src2_idx == ex_idx_q);
    assign hit_wb1 = in_src1_used & wb_vld_q & (in_src1_idx == wb_idx_q);
    assign hit_wb2 = in_src2_used & wb_vld_q & (in_src2_idx == wb_idx_q);
    assign raw     = hit_ex1 | hit_ex2 | hit_wb1 | hit_wb2;
    // With forwarding every in-flight producer is reachable, so RAW never stalls.
    assign hz      = (FWD_ENABLE != 0) ? 1'b0 : raw;

    // Flush outranks the hazard stall; both are ignored outside RUN.
    assign run       = (state_q == ST_RUN);
    assign accepted  = run & in_issue_valid & ~hz & ~in_flush;
    assign stall_raw = run & in_issue_valid &  hz & ~in_flush;
    assign flush_acc = run & in_flush;

    // Combinational outputs are held low while reset is asserted.
    assign out_issue = accepted  & ~reset;
    assign out_stall = stall_raw & ~reset;
    assign out_fwd_sel_src1 = ((FWD_ENABLE != 0) && out_issue) ? fwd_pick(hit_ex1, hit_wb1) : FWD_REG;
    assign out_fwd_sel_src2 = ((FWD_ENABLE != 0) && out_issue) ? fwd_pick(hit_ex2, hit_wb2) : FWD_REG;
    assign out_state = (state_q == ST_FLUSH);

    // A squashed or stalled decode leaves a bubble in exec; non-writers never occupy a slot.
    assign ex_vld_d = accepted & in_dst_write;
    assign ex_idx_d = accepted ? in_dst_idx : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_RUN;
            bub_q    <= '0;
            ex_vld_q <= 1'b0;
            ex_idx_q <= '0;
            wb_vld_q <= 1'b0;
            wb_idx_q <= '0;
        end else begin
            // The jump in exec keeps flowing to writeback even on a flush (link write).
            wb_vld_q <= ex_vld_q;
            wb_idx_q <= ex_idx_q;
            ex_vld_q <= ex_vld_d;
            ex_idx_q <= ex_idx_d;
            case (state_q)
                ST_RUN: begin
                    if (in_flush && (FLUSH_BUBBLES > 1)) begin
                        state_q <= ST_FLUSH;
                        bub_q   <= RELOAD;
                    end
                end
                ST_FLUSH: begin
                    if (in_flush) begin
                        bub_q <= RELOAD;
                    end else if (bub_q == BW'(1)) begin
                        state_q <= ST_RUN;
                        bub_q   <= '0;
                    end else begin
                        bub_q <= bub_q - BW'(1);
                    end
                end
                default: begin
                    state_q <= ST_RUN;
                    bub_q   <= '0;
                end
            endcase
        end
    end

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk_i (clock),
        .rst_i (reset),
        .inc_i (out_stall),
        .clr_i (in_cnt_clear),
        .cnt_o (out_stall_cnt)
    );

    // Only the flush that leaves RUN is an event; re-flushes inside the window are not.
    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk_i (clock),
        .rst_i (reset),
        .inc_i (flush_acc),
        .clr_i (in_cnt_clear),
        .cnt_o (out_flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Two controllers share one input stream: F forwards (FLUSH_BUBBLES=2, 16-bit counters),
// S stalls on every RAW hazard (FLUSH_BUBBLES=3, 4-bit counters).
// A driver pushes per-cycle expectations from a reference model; a negedge monitor pops and compares.
module tb_hazard_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       iv, u1, u2, dw, fl, clr;
    logic [3:0] s1, s2, di;

    logic        f_issue, f_stall, f_st;
    logic [1:0]  f_f1, f_f2;
    logic [15:0] f_sc, f_fc;
    logic        s_issue, s_stall, s_st;
    logic [1:0]  s_f1, s_f2;
    logic [3:0]  s_sc, s_fc;

    always #5 clock = ~clock;

    hazard_ctrl #(.REG_IDX_WIDTH(4), .FWD_ENABLE(1), .FLUSH_BUBBLES(2), .CNT_WIDTH(16)) dut_f (
        .clock(clock), .reset(reset), .in_issue_valid(iv),
        .in_src1_used(u1), .in_src1_idx(s1), .in_src2_used(u2), .in_src2_idx(s2),
        .in_dst_write(dw), .in_dst_idx(di), .in_flush(fl), .in_cnt_clear(clr),
        .out_issue(f_issue), .out_stall(f_stall), .out_fwd_sel_src1(f_f1),
        .out_fwd_sel_src2(f_f2), .out_state(f_st), .out_stall_cnt(f_sc), .out_flush_cnt(f_fc)
    );

    hazard_ctrl #(.REG_IDX_WIDTH(4), .FWD_ENABLE(0), .FLUSH_BUBBLES(3), .CNT_WIDTH(4)) dut_s (
        .clock(clock), .reset(reset), .in_issue_valid(iv),
        .in_src1_used(u1), .in_src1_idx(s1), .in_src2_used(u2), .in_src2_idx(s2),
        .in_dst_write(dw), .in_dst_idx(di), .in_flush(fl), .in_cnt_clear(clr),
        .out_issue(s_issue), .out_stall(s_stall), .out_fwd_sel_src1(s_f1),
        .out_fwd_sel_src2(s_f2), .out_state(s_st), .out_stall_cnt(s_sc), .out_flush_cnt(s_fc)
    );

    typedef struct {
        int issue; int stall; int f1; int f2; int st; int sc; int fc;
    } exp_t;

    exp_t qf[$];
    exp_t qs[$];

    // Reference model: per instance, the list of in-flight writers (exec, writeback),
    // remaining refill cycles, and the two event tallies.
    int fwdk[2] = '{1, 0};
    int fbk[2]  = '{2, 3};
    int maxk[2] = '{65535, 15};
    int exv[2], exi[2], wbv[2], wbi[2], bub[2], sc[2], fc[2];

    int n_checks = 0;
    int n_errs   = 0;
    bit mon_en   = 0;
    int cyc      = 0;

    task automatic chk(input string nm, input int got, input int expv);
        n_checks++;
        if (got != expv) begin
            n_errs++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", nm, cyc, got, expv);
        end
    endtask

    task automatic model_step(input int k, output exp_t e);
        int h_ex1, h_ex2, h_wb1, h_wb2, hazard, flushing;
        e.issue = 0; e.stall = 0; e.f1 = 0; e.f2 = 0; e.st = 0; e.sc = 0; e.fc = 0;
        if (reset) begin
            exv[k] = 0; wbv[k] = 0; bub[k] = 0; sc[k] = 0; fc[k] = 0;
            return;
        end
        flushing = (bub[k] > 0);
        h_ex1 = u1 && exv[k] != 0 && int'(s1) == exi[k];
        h_ex2 = u2 && exv[k] != 0 && int'(s2) == exi[k];
        h_wb1 = u1 && wbv[k] != 0 && int'(s1) == wbi[k];
        h_wb2 = u2 && wbv[k] != 0 && int'(s2) == wbi[k];
        hazard = (fwdk[k] == 0) && (h_ex1 || h_ex2 || h_wb1 || h_wb2);
        if (!flushing && !fl) begin
            e.stall = iv && hazard;
            e.issue = iv && !hazard;
        end
        if (e.issue != 0 && fwdk[k] != 0) begin
            e.f1 = h_ex1 ? 1 : (h_wb1 ? 2 : 0);
            e.f2 = h_ex2 ? 1 : (h_wb2 ? 2 : 0);
        end
        e.st = flushing;
        e.sc = sc[k];
        e.fc = fc[k];
        // advance to the next cycle
        if (clr) sc[k] = 0; else if (e.stall != 0 && sc[k] < maxk[k]) sc[k]++;
        if (clr) fc[k] = 0; else if (fl && !flushing && fc[k] < maxk[k]) fc[k]++;
        if (flushing) bub[k] = fl ? fbk[k] - 1 : bub[k] - 1;
        else if (fl)  bub[k] = fbk[k] - 1;
        wbv[k] = exv[k];
        wbi[k] = exi[k];
        exv[k] = (e.issue != 0) && dw;
        exi[k] = int'(di);
    endtask

    task automatic apply(input bit a_iv, input bit a_u1, input int a_s1, input bit a_u2,
                         input int a_s2, input bit a_dw, input int a_di, input bit a_fl,
                         input bit a_clr, input bit a_rs);
        exp_t e;
        iv = a_iv; u1 = a_u1; s1 = 4'(a_s1); u2 = a_u2; s2 = 4'(a_s2);
        dw = a_dw; di = 4'(a_di); fl = a_fl; clr = a_clr; reset = a_rs;
        model_step(0, e); qf.push_back(e);
        model_step(1, e); qs.push_back(e);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic drv(input bit a_iv, input bit a_u1, input int a_s1, input bit a_u2,
                       input int a_s2, input bit a_dw, input int a_di, input bit a_fl,
                       input bit a_clr, input bit a_rs);
        apply(a_iv, a_u1, a_s1, a_u2, a_s2, a_dw, a_di, a_fl, a_clr, a_rs);
        step();
    endtask

    // Monitor: every cycle both controllers present a full output set.
    always @(negedge clock) begin
        if (mon_en) begin
            if (qf.size() == 0 || qs.size() == 0) begin
                n_checks++;
                n_errs++;
                $display("FAIL scoreboard_empty cycle=%0d got=no expectation required=one", cyc);
            end else begin
                exp_t ef, es;
                ef = qf.pop_front();
                es = qs.pop_front();
                chk("F.issue", int'(f_issue), ef.issue);
                chk("F.stall", int'(f_stall), ef.stall);
                chk("F.fwd1",  int'(f_f1),    ef.f1);
                chk("F.fwd2",  int'(f_f2),    ef.f2);
                chk("F.state", int'(f_st),    ef.st);
                chk("F.scnt",  int'(f_sc),    ef.sc);
                chk("F.fcnt",  int'(f_fc),    ef.fc);
                chk("S.issue", int'(s_issue), es.issue);
                chk("S.stall", int'(s_stall), es.stall);
                chk("S.fwd1",  int'(s_f1),    es.f1);
                chk("S.fwd2",  int'(s_f2),    es.f2);
                chk("S.state", int'(s_st),    es.st);
                chk("S.scnt",  int'(s_sc),    es.sc);
                chk("S.fcnt",  int'(s_fc),    es.fc);
            end
        end
    end

    initial begin
        reset = 1'b1;
        iv = 0; u1 = 0; u2 = 0; dw = 0; fl = 0; clr = 0; s1 = 0; s2 = 0; di = 0;
        @(posedge clock);
        #1;
        mon_en = 1;

        // reset state
        apply(1, 1, 0, 1, 0, 1, 0, 1, 0, 1); #1;
        chk("rst_issue", int'(f_issue), 0);
        chk("rst_stall_cnt", int'(s_sc), 0);
        step();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // 1: forwarding from exec, then from writeback
        drv(1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
        apply(1, 1, 3, 1, 4, 0, 0, 0, 0, 0); #1;
        chk("t1_issue", int'(f_issue), 1);
        chk("t1_fwd1_ex", int'(f_f1), 1);
        chk("t1_fwd2_reg", int'(f_f2), 0);
        step();
        apply(1, 0, 0, 1, 3, 0, 0, 0, 0, 0); #1;
        chk("t1_fwd2_wb", int'(f_f2), 2);
        step();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

        // 2: stall two cycles without forwarding
        drv(1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
        apply(1, 1, 5, 0, 0, 0, 0, 0, 0, 0); #1;
        chk("t2_stall_s", int'(s_stall), 1);
        step();
        drv(1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
        apply(1, 1, 5, 0, 0, 0, 0, 0, 0, 0); #1;
        chk("t2_issue_s", int'(s_issue), 1);
        chk("t2_scnt_s", int'(s_sc), 2);
        step();

        // 3: flush with decode valid, jump writes link r7
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 1, 7, 0, 0, 0);
        apply(1, 0, 0, 0, 0, 1, 8, 1, 0, 0); #1;
        chk("t3_issue_flush", int'(f_issue), 0);
        chk("t3_stall_flush", int'(f_stall), 0);
        step();
        apply(1, 1, 7, 0, 0, 0, 0, 0, 0, 0); #1;
        chk("t3_state_f", int'(f_st), 1);
        chk("t3_issue_refill", int'(f_issue), 0);
        chk("t3_fcnt_f", int'(f_fc), 1);
        step();
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        chk("t3_state_run", int'(f_st), 0);
        step();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // 4: flush coinciding with a RAW hazard
        drv(1, 0, 0, 0, 0, 1, 9, 0, 0, 0);
        apply(1, 1, 9, 0, 0, 0, 0, 1, 0, 0); #1;
        chk("t4_stall_s", int'(s_stall), 0);
        chk("t4_issue_s", int'(s_issue), 0);
        step();
        chk("t4_state_s", int'(s_st), 1);
        chk("t4_scnt_s", int'(s_sc), 2);
        repeat (3) drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // 5: saturate the 4-bit stall counter, then clear against a stall
        drv(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        repeat (30) drv(1, 1, 1, 0, 0, 1, 1, 0, 0, 0);
        apply(1, 1, 1, 0, 0, 1, 1, 0, 1, 0); #1;
        chk("t5_sat_s", int'(s_sc), 15);
        chk("t5_stall_at_clr", int'(s_stall), 1);
        step();
        chk("t5_clr_s", int'(s_sc), 0);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // 6: reset during the refill window
        drv(1, 0, 0, 0, 0, 1, 2, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        apply(1, 1, 2, 0, 0, 0, 0, 0, 0, 1); #1;
        chk("t6_rst_state", int'(f_st), 0);
        chk("t6_rst_fcnt", int'(f_fc), 0);
        chk("t6_rst_issue", int'(f_issue), 0);
        step();
        apply(1, 1, 2, 1, 2, 0, 0, 0, 0, 0); #1;
        chk("t6_fwd1_after_rst", int'(f_f1), 0);
        chk("t6_issue_after_rst", int'(f_issue), 1);
        chk("t6_stall_after_rst", int'(s_stall), 0);
        step();

        // randomized traffic over a small register window to provoke hits
        for (int n = 0; n < 600; n++) begin
            drv($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0, $urandom_range(0, 3),
                $urandom_range(0, 1) != 0, $urandom_range(0, 3),
                $urandom_range(0, 3) != 0, $urandom_range(0, 3),
                $urandom_range(0, 15) == 0, $urandom_range(0, 40) == 0,
                $urandom_range(0, 120) == 0);
        end
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        mon_en = 0;

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
